// File: rtl/half_subtractor_pkg.sv
// Shared types and the per-bit
// half-subtract rule.
package half_subtractor_pkg;

  typedef struct packed {
    logic d;
    logic bo;
  } hs_bit_t;

  function automatic hs_bit_t hs_eval(
    input logic a,
    input logic b
  );
    hs_bit_t r;
    r.d  = a ^ b;
    r.bo = ~a & b;
    return r;
  endfunction

endpackage

// File: rtl/half_subtractor_cell.sv
// One-bit combinational half
// subtractor lane.
module half_sub_cell
  import half_subtractor_pkg::*;
(
  output logic d,
  output logic bo,
  input  logic a,
  input  logic b
);

  hs_bit_t w_res;

  assign w_res = hs_eval(a, b);
  assign d     = w_res.d;
  assign bo    = w_res.bo;

endmodule

// File: rtl/half_subtractor.sv
// Bitwise half subtractor with a
// live combinational path and a 1-cycle registered copy.
module half_subtractor #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Bo,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic [WIDTH-1:0] d_q,
  output logic [WIDTH-1:0] bo_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] w_d;
  logic [WIDTH-1:0] w_bo;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_bo;
  logic             r_vld;

  // Lanes are independent: no borrow chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_sub_cell u_cell (
      .d  (w_d[i]),
      .bo (w_bo[i]),
      .a  (A[i]),
      .b  (B[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d   <= '0;
      r_bo  <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_d  <= w_d;
        r_bo <= w_bo;
      end
    end
  end

  assign D         = w_d;
  assign Bo        = w_bo;
  assign d_q       = r_d;
  assign bo_q      = r_bo;
  assign out_valid = r_vld;

endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: directed
// checks at WIDTH 1/4 and a scoreboarded random run at WIDTH 8.
module tb_half_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // WIDTH=1 instance
  logic a1 = 0, b1 = 0, v1 = 0;
  logic d1, bo1, dq1, boq1, ov1;
  half_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .D(d1), .Bo(bo1),
    .A(a1), .B(b1), .in_valid(v1),
    .d_q(dq1), .bo_q(boq1), .out_valid(ov1)
  );

  // WIDTH=4 instance
  logic [3:0] a4 = '0, b4 = '0;
  logic       v4 = 0;
  logic [3:0] d4, bo4, dq4, boq4;
  logic       ov4;
  half_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .D(d4), .Bo(bo4),
    .A(a4), .B(b4), .in_valid(v4),
    .d_q(dq4), .bo_q(boq4), .out_valid(ov4)
  );

  // WIDTH=8 instance
  logic [7:0] a8 = '0, b8 = '0;
  logic       v8 = 0;
  logic [7:0] d8, bo8, dq8, boq8;
  logic       ov8;
  half_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .D(d8), .Bo(bo8),
    .A(a8), .B(b8), .in_valid(v8),
    .d_q(dq8), .bo_q(boq8), .out_valid(ov8)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: per lane, diff = a - b in {-1,0,1};
  // difference bit is diff mod 2, borrow is diff < 0.
  function automatic void ref_sub(input logic [7:0] a,
                                  input logic [7:0] b,
                                  output logic [7:0] d,
                                  output logic [7:0] bo);
    d  = '0;
    bo = '0;
    for (int i = 0; i < 8; i++) begin
      int diff;
      diff  = int'(a[i]) - int'(b[i]);
      d[i]  = (diff != 0);
      bo[i] = (diff < 0);
    end
  endfunction

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] bo;
  } exp_t;

  exp_t sb_q[$];
  logic [7:0] last_d  = '0;
  logic [7:0] last_bo = '0;

  // Monitor: one entry per clock of the random run.
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_out_valid", 32'(ov8), 32'(e.v));
      if (e.v) begin
        last_d  = e.d;
        last_bo = e.bo;
      end
      chk("sb_d_q", 32'(dq8), 32'(last_d));
      chk("sb_bo_q", 32'(boq8), 32'(last_bo));
    end
  end

  logic [1:0] ab;
  logic [1:0] exp_tt [4];

  initial begin
    logic [7:0] ed, eb;
    exp_t e;
    int   guard;

    exp_tt[0] = 2'b00;
    exp_tt[1] = 2'b11;
    exp_tt[2] = 2'b10;
    exp_tt[3] = 2'b00;

    // Reset state and live comb path during reset
    #1;
    chk("rst_dq1", 32'(dq1), 0);
    chk("rst_ov1", 32'(ov1), 0);
    chk("rst_ov8", 32'(ov8), 0);
    a1 = 0; b1 = 1; v1 = 1;
    @(posedge clk); #1;
    chk("rst_comb_D", 32'(d1), 1);
    chk("rst_comb_Bo", 32'(bo1), 1);
    chk("rst_hold_dq", 32'(dq1), 0);
    chk("rst_hold_boq", 32'(boq1), 0);
    chk("rst_hold_ov", 32'(ov1), 0);

    @(negedge clk);
    v1 = 0;
    rst_n = 1;

    // Truth table
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a1 = ab[1];
      b1 = ab[0];
      #1;
      chk("tt_D", 32'(d1), 32'(exp_tt[i][1]));
      chk("tt_Bo", 32'(bo1), 32'(exp_tt[i][0]));
      #9;
    end

    // One valid edge then hold
    @(negedge clk);
    a1 = 1; b1 = 0; v1 = 1;
    @(posedge clk); #1;
    chk("reg_dq", 32'(dq1), 1);
    chk("reg_boq", 32'(boq1), 0);
    chk("reg_ov", 32'(ov1), 1);
    v1 = 0; a1 = 0; b1 = 1;
    @(posedge clk); #1;
    chk("hold_ov", 32'(ov1), 0);
    chk("hold_dq", 32'(dq1), 1);
    chk("hold_boq", 32'(boq1), 0);

    // Asynchronous reset between edges
    @(negedge clk);
    a1 = 0; b1 = 1; v1 = 1;
    @(posedge clk); #1;
    chk("pre_ar_ov", 32'(ov1), 1);
    chk("pre_ar_boq", 32'(boq1), 1);
    #1;
    rst_n = 0;
    #1;
    chk("ar_dq", 32'(dq1), 0);
    chk("ar_boq", 32'(boq1), 0);
    chk("ar_ov", 32'(ov1), 0);
    @(posedge clk); #1;
    chk("ar_held_ov", 32'(ov1), 0);
    @(negedge clk);
    v1 = 0;
    rst_n = 1;

    // WIDTH=4 vector
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b1010; v4 = 1;
    #1;
    chk("w4_D", 32'(d4), 32'h6);
    chk("w4_Bo", 32'(bo4), 32'h2);
    @(posedge clk); #1;
    chk("w4_dq", 32'(dq4), 32'h6);
    chk("w4_boq", 32'(boq4), 32'h2);
    chk("w4_ov", 32'(ov4), 1);
    v4 = 0;

    // Random run at WIDTH=8
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = 1'($urandom_range(0, 1));
      ref_sub(a8, b8, ed, eb);
      e.v = v8; e.d = ed; e.bo = eb;
      sb_q.push_back(e);
      #1;
      chk("rnd_D", 32'(d8), 32'(ed));
      chk("rnd_Bo", 32'(bo8), 32'(eb));
    end
    @(negedge clk);
    v8 = 0;

    guard = 0;
    while (sb_q.size() > 0 && guard < 5) begin
      @(negedge clk);
      guard++;
    end
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
